// File: rtl/microwave_btn_scheduler_pkg.sv
// microwave_btn_pkg
//   Shared types, defaults and helpers for the microwave panel button
//   scheduler.
//   Contents:
//     state_t              - command FSM states (IDLE, OFFER)
//     DEFAULT_TICK_DIV     - default tick period in clk cycles
//     DEFAULT_REPEAT_TICKS - default held ticks per auto-repeat event
//     MAX_BTN              - largest supported button count
//     rr_first_set()       - cyclic first-set search used by the arbiter
package microwave_btn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int DEFAULT_TICK_DIV     = 10000000;
  localparam int DEFAULT_REPEAT_TICKS = 8;
  localparam int MAX_BTN              = 8;

  // Returns the first set index of vec[n-1:0] found by walking from ptr
  // upward and wrapping at n. Returns 0 when nothing is set; callers
  // qualify the result with their own any-set flag.
  function automatic logic [2:0] rr_first_set(input logic [MAX_BTN-1:0] vec,
                                              input logic [2:0]         ptr,
                                              input int                 n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_BTN; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && vec[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/microwave_btn_scheduler_if.sv
// microwave_btn_scheduler_if
//   Valid/ready command stream from the button scheduler to the microwave
//   control FSM.
//   Signals:
//     cmd_valid  - command offered (scheduler -> consumer)
//     cmd_ready  - consumer accepts the command (consumer -> scheduler)
//     cmd_id     - index of the granted button
//     cmd_repeat - 1 = auto-repeat event, 0 = fresh press
//   Modports: master (scheduler side), slave (consumer side).
interface microwave_btn_scheduler_if #(
  parameter int ID_W = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_repeat;

  modport master (output cmd_valid, output cmd_id, output cmd_repeat,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_id, input  cmd_repeat,
                  output cmd_ready);
endinterface

// File: rtl/microwave_btn_scheduler_rr_arbiter.sv
// microwave_btn_rr_arbiter
//   Purely combinational round-robin pick over the pending vector. The
//   pointer register lives in the parent so that it only advances when a
//   grant is actually taken.
//   Ports:
//     pending     in  N_BTN - one bit per button with a queued event
//     ptr         in  ID_W  - index with highest priority this cycle
//     grant_id    out ID_W  - first pending index at or after ptr (cyclic)
//     any_pending out 1     - at least one bit of pending is set
module microwave_btn_rr_arbiter
  import microwave_btn_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int ID_W  = $clog2(N_BTN)
) (
  input  logic [N_BTN-1:0] pending,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant_id,
  output logic             any_pending
);

  logic [MAX_BTN-1:0] vec;

  always_comb begin
    vec                = '0;
    vec[N_BTN-1:0]     = pending;
    grant_id           = ID_W'(rr_first_set(vec, 3'(ptr), N_BTN));
    any_pending        = |pending;
  end

endmodule

// File: rtl/microwave_btn_scheduler.sv
// microwave_btn_scheduler
//   Shared button front-end and command scheduler for the microwave panel.
//   One tick generator serves all buttons; each button is synchronised,
//   sampled on ticks for rising edges, queued in a pending register and
//   arbitrated round-robin onto a single valid/ready command stream.
//   Optional feature: define MICROWAVE_AUTOREPEAT_EN to add per-button hold
//   counters that raise auto-repeat commands every REPEAT_TICKS held ticks.
//   Ports:
//     clk     in  1     - system clock
//     reset   in  1     - asynchronous, active-high reset
//     btn_raw in  N_BTN - raw asynchronous buttons, active-high
//     tick    out 1     - one-cycle sample strobe for other panel blocks
//     cmd     master    - command stream (cmd_valid/cmd_ready/cmd_id/cmd_repeat)
module microwave_btn_scheduler
  import microwave_btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic                     tick,
  microwave_btn_scheduler_if.master cmd
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = $clog2(TICK_DIV);

  if (N_BTN < 2 || N_BTN > MAX_BTN) begin : g_bad_n_btn
    $error("microwave_btn_scheduler: N_BTN must be 2..8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("microwave_btn_scheduler: TICK_DIV must be >= 2");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat_ticks
    $error("microwave_btn_scheduler: REPEAT_TICKS must be >= 1");
  end

  logic [CNT_W-1:0] tick_cnt;
  logic [N_BTN-1:0] sync1, s, q1, q2;
  logic [N_BTN-1:0] press_evt, rep_evt, rep_flag;
  logic [N_BTN-1:0] pending, grant_clr, still_pending;
  logic [ID_W-1:0]  ptr, grant_id;
  logic             any_pending;
  state_t           state;
  logic             cmd_valid_q, cmd_repeat_q;
  logic [ID_W-1:0]  cmd_id_q;

  // Free-running tick divider; tick is high for the last count of a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                tick_cnt <= '0;
    else if (tick_cnt == CNT_W'(TICK_DIV - 1)) tick_cnt <= '0;
    else                                      tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Two-flop synchroniser followed by tick-enabled samplers. Sampling only
  // on ticks is what filters bounce shorter than one tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
      q1    <= '0;
      q2    <= '0;
    end else begin
      sync1 <= btn_raw;
      s     <= sync1;
      if (tick) begin
        q1 <= s;
        q2 <= q1;
      end
    end
  end

  assign press_evt = {N_BTN{tick}} & q1 & ~q2;

`ifdef MICROWAVE_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);

  // Per-button hold counter: counts ticks where the button was already held
  // on the previous tick, fires a repeat on reaching REPEAT_TICKS and
  // restarts. Any tick with the button not held clears it.
  for (genvar i = 0; i < N_BTN; i++) begin : g_hold
    logic [HOLD_W-1:0] hold_cnt;

    assign rep_evt[i] = tick & q1[i] & q2[i] &
                        (hold_cnt == HOLD_W'(REPEAT_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) hold_cnt <= '0;
      else if (tick) begin
        if (!(q1[i] & q2[i]) || rep_evt[i]) hold_cnt <= '0;
        else                                hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Repeat flag per pending bit: a press always marks a fresh command, a
  // repeat only marks the bit when it is not already queued, so a repeat
  // merged into a waiting press keeps the press flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_flag <= '0;
    else       rep_flag <= ~press_evt & (rep_flag | (rep_evt & ~still_pending));
  end
`else
  assign rep_evt  = '0;
  assign rep_flag = '0;
`endif

  microwave_btn_rr_arbiter #(
    .N_BTN (N_BTN),
    .ID_W  (ID_W)
  ) u_arb (
    .pending     (pending),
    .ptr         (ptr),
    .grant_id    (grant_id),
    .any_pending (any_pending)
  );

  // The bit taken by the FSM this cycle; only IDLE can take a grant.
  always_comb begin
    grant_clr = '0;
    if (state == IDLE && any_pending) grant_clr[grant_id] = 1'b1;
    still_pending = pending & ~grant_clr;
  end

  // Pending bits: new events are ORed in after the grant clear so that a
  // set and clear in the same cycle leaves the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= still_pending | press_evt | rep_evt;
  end

  // Command FSM. The grant is loaded in IDLE and offered from the next
  // cycle; the return to IDLE after each handshake guarantees a gap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      cmd_repeat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            cmd_id_q     <= grant_id;
            cmd_repeat_q <= rep_flag[grant_id];
            cmd_valid_q  <= 1'b1;
            ptr          <= (grant_id == ID_W'(N_BTN - 1)) ? '0
                                                            : grant_id + 1'b1;
            state        <= OFFER;
          end
        end
        OFFER: begin
          if (cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_id     = cmd_id_q;
  assign cmd.cmd_repeat = cmd_repeat_q;

endmodule
